// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment display scan path.
package display_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t        SEG_OFF   = 8'hFF;
  localparam seg_t        SEG_ZERO  = 8'b00000011;
  localparam logic [3:0]  ANODE_OFF = 4'hF;

  typedef enum logic {BLANK, SHOW} scan_state_t;

endpackage

// File: rtl/display_scan_mux_if.sv
// Pattern inputs and multiplexed drive outputs of display_scan_mux.
interface display_scan_mux_if;
  import display_pkg::*;

  logic [3:0] dig_en;
  seg_t       catodo1;
  seg_t       catodo2;
  seg_t       catodo3;
  seg_t       catodo4;
  logic [3:0] anodo;
  seg_t       catodo;
  logic       frame_tick;

  modport master (
    output dig_en, catodo1, catodo2, catodo3, catodo4,
    input  anodo, catodo, frame_tick
  );

  modport slave (
    input  dig_en, catodo1, catodo2, catodo3, catodo4,
    output anodo, catodo, frame_tick
  );

endinterface

// File: rtl/display_scan_mux_scan_timer.sv
// Slot phase / digit index counters; exposes next-state values and the frame boundary.
module scan_timer #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned PW          = $clog2(REFRESH_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [PW-1:0] o_phase_nxt_c,
  output logic [1:0]    o_idx_nxt_c,
  output logic          o_frame_c
);

  logic [PW-1:0] r_phase;
  logic [1:0]    r_idx;
  logic          r_run;
  logic          w_wrap;

  // First edge after reset holds phase at 0 so every frame starts on phase 0 of digit 1
  always_comb begin
    w_wrap        = (r_phase == PW'(REFRESH_DIV - 1));
    o_phase_nxt_c = r_phase + PW'(1);
    o_idx_nxt_c   = r_idx;
    o_frame_c     = 1'b0;
    if (!r_run) begin
      o_phase_nxt_c = '0;
      o_idx_nxt_c   = 2'd0;
      o_frame_c     = 1'b1;
    end else if (w_wrap) begin
      o_phase_nxt_c = '0;
      o_idx_nxt_c   = r_idx + 2'd1;
      o_frame_c     = (r_idx == 2'd3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_idx   <= 2'd0;
      r_run   <= 1'b0;
    end else begin
      r_phase <= o_phase_nxt_c;
      r_idx   <= o_idx_nxt_c;
      r_run   <= 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit 7-segment scan multiplexer with per-frame snapshot and blanking.
// Optional leading-zero suppression when DISPLAY_ZERO_BLANK_EN is defined.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic               clk,
  input logic               rst_n,
  display_scan_mux_if.slave bus
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);

  logic [PW-1:0] w_phase_nxt;
  logic [1:0]    w_idx_nxt;
  logic          w_frame;

  seg_t          r_snap [4];
  logic [3:0]    r_en_q;
  logic [3:0]    r_anodo;
  seg_t          r_catodo;
  logic          r_frame_tick;

  seg_t          w_snap_nxt [4];
  logic [3:0]    w_en_nxt;
  logic [3:0]    w_zb;
  logic [3:0]    w_lit;
  scan_state_t   w_state_nxt;
  logic [3:0]    w_anodo_nxt;
  seg_t          w_catodo_nxt;

  scan_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .PW          (PW)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_phase_nxt_c (w_phase_nxt),
    .o_idx_nxt_c   (w_idx_nxt),
    .o_frame_c     (w_frame)
  );

  // Snapshot inputs only at the frame boundary so a frame never mixes patterns
  always_comb begin
    w_snap_nxt = r_snap;
    w_en_nxt   = r_en_q;
    if (w_frame) begin
      w_snap_nxt[0] = bus.catodo1;
      w_snap_nxt[1] = bus.catodo2;
      w_snap_nxt[2] = bus.catodo3;
      w_snap_nxt[3] = bus.catodo4;
      w_en_nxt      = bus.dig_en;
    end
  end

`ifdef DISPLAY_ZERO_BLANK_EN
  always_comb begin
    w_zb    = 4'b0000;
    w_zb[3] = (w_snap_nxt[3] == SEG_ZERO);
    w_zb[2] = w_zb[3] && (w_snap_nxt[2] == SEG_ZERO);
    w_zb[1] = w_zb[2] && (w_snap_nxt[1] == SEG_ZERO);
  end
`else
  assign w_zb = 4'b0000;
`endif

  assign w_lit = w_en_nxt & ~w_zb;

  // Outputs are computed from next-state values so they line up with the phase register
  always_comb begin
    w_state_nxt  = (32'(w_phase_nxt) < BLANK_CYCLES) ? BLANK : SHOW;
    w_anodo_nxt  = ANODE_OFF;
    w_catodo_nxt = SEG_OFF;
    if (w_state_nxt == SHOW && w_lit[w_idx_nxt]) begin
      w_anodo_nxt  = ~(4'b0001 << w_idx_nxt);
      w_catodo_nxt = w_snap_nxt[w_idx_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_snap[i] <= SEG_OFF;
      r_en_q       <= 4'h0;
      r_anodo      <= ANODE_OFF;
      r_catodo     <= SEG_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_snap       <= w_snap_nxt;
      r_en_q       <= w_en_nxt;
      r_anodo      <= w_anodo_nxt;
      r_catodo     <= w_catodo_nxt;
      r_frame_tick <= w_frame;
    end
  end

  assign bus.anodo      = r_anodo;
  assign bus.catodo     = r_catodo;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed, table-driven bench for display_scan_mux (REFRESH_DIV=8, BLANK_CYCLES=2).
module tb_display_scan_mux;
  import display_pkg::*;

  typedef struct {
    logic [3:0]      en;
    logic [7:0]      c1, c2, c3, c4;
    logic [3:0][3:0] an;
    logic [3:0][7:0] cat;
    int              chg_cyc;
    logic [7:0]      chg_val;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [6];

  always #5 clk = ~clk;

  display_scan_mux_if u_if ();

  display_scan_mux #(
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  function automatic vec_t mk(input logic [3:0] en, input logic [7:0] c1, input logic [7:0] c2,
                              input logic [7:0] c3, input logic [7:0] c4, input logic [15:0] an,
                              input logic [31:0] cat, input int chg_cyc, input logic [7:0] chg_val);
    vec_t v;
    v.en = en; v.c1 = c1; v.c2 = c2; v.c3 = c3; v.c4 = c4;
    v.an = an; v.cat = cat; v.chg_cyc = chg_cyc; v.chg_val = chg_val;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    u_if.dig_en  = v.en;
    u_if.catodo1 = v.c1;
    u_if.catodo2 = v.c2;
    u_if.catodo3 = v.c3;
    u_if.catodo4 = v.c4;
  endtask

  task automatic check_inv;
    chk("one_anode_max", 32'($countones(~u_if.anodo) <= 1), 32'd1);
    if (u_if.anodo == 4'hF) chk("dark_cathode", 32'(u_if.catodo), 32'hFF);
  endtask

  // Bounded wait for the next frame_tick; reports cycles taken
  task automatic wait_frame(input string name, input int exp_cycles);
    int n = 0;
    do begin
      tick;
      n++;
    end while (!u_if.frame_tick && n < 64);
    chk(name, 32'(n), 32'(exp_cycles));
  endtask

  // Called on cycle 0 of a frame; walks all 32 cycles
  task automatic check_frame(input vec_t v, input int id);
    for (int c = 0; c < 32; c++) begin
      int s;
      int p;
      if (c > 0) tick;
      s = c / 8;
      p = c % 8;
      chk($sformatf("anodo v%0d c%0d", id, c), 32'(u_if.anodo), (p < 2) ? 32'hF : 32'(v.an[s]));
      chk($sformatf("catodo v%0d c%0d", id, c), 32'(u_if.catodo), (p < 2) ? 32'hFF : 32'(v.cat[s]));
      chk($sformatf("frame_tick v%0d c%0d", id, c), 32'(u_if.frame_tick), (c == 0) ? 32'd1 : 32'd0);
      check_inv;
      if (c == v.chg_cyc) u_if.catodo2 = v.chg_val;
    end
  endtask

  initial begin
    vec_t v;
    vecs[0] = mk(4'hF, 8'h9F, 8'h25, 8'h0D, 8'h99, 16'h7BDE, 32'h990D259F, 12, 8'h01);
    vecs[1] = mk(4'hF, 8'h9F, 8'h01, 8'h0D, 8'h99, 16'h7BDE, 32'h990D019F, -1, 8'h00);
    vecs[2] = mk(4'h5, 8'h9F, 8'h01, 8'h0D, 8'h99, 16'hFBFE, 32'hFF0DFF9F, -1, 8'h00);
`ifdef DISPLAY_ZERO_BLANK_EN
    vecs[3] = mk(4'hF, 8'h03, 8'h9F, 8'h03, 8'h03, 16'hFFDE, 32'hFFFF9F03, -1, 8'h00);
    vecs[5] = mk(4'hF, 8'h03, 8'h03, 8'h9F, 8'h03, 16'hFBDE, 32'hFF9F0303, -1, 8'h00);
`else
    vecs[3] = mk(4'hF, 8'h03, 8'h9F, 8'h03, 8'h03, 16'h7BDE, 32'h03039F03, -1, 8'h00);
    vecs[5] = mk(4'hF, 8'h03, 8'h03, 8'h9F, 8'h03, 16'h7BDE, 32'h039F0303, -1, 8'h00);
`endif
    vecs[4] = mk(4'h8, 8'h11, 8'h22, 8'h33, 8'h44, 16'h7FFF, 32'h44FFFFFF, -1, 8'h00);

    apply(vecs[0]);
    repeat (3) tick;
    chk("reset anodo", 32'(u_if.anodo), 32'hF);
    chk("reset catodo", 32'(u_if.catodo), 32'hFF);
    chk("reset frame_tick", 32'(u_if.frame_tick), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (i > 0) apply(vecs[i]);
      wait_frame($sformatf("frame_period v%0d", i), 1);
      check_frame(vecs[i], i);
    end

    // Four more frames of varied inputs, checking only the safety invariants
    for (int f = 0; f < 4; f++) begin
      u_if.dig_en  = 4'($urandom_range(0, 15));
      u_if.catodo1 = 8'($urandom_range(0, 255));
      u_if.catodo2 = 8'($urandom_range(0, 255));
      u_if.catodo3 = 8'($urandom_range(0, 255));
      u_if.catodo4 = 8'($urandom_range(0, 255));
      wait_frame($sformatf("frame_period r%0d", f), 1);
      check_inv;
      for (int c = 1; c < 32; c++) begin
        tick;
        check_inv;
        chk("frame_tick quiet", 32'(u_if.frame_tick), 32'd0);
      end
    end

    // Asynchronous reset during digit 3's SHOW slot
    v = vecs[0];
    v.chg_cyc = -1;
    apply(v);
    wait_frame("frame_period pre_reset", 1);
    repeat (20) tick;
    chk("pre_reset anodo", 32'(u_if.anodo), 32'hB);
    chk("pre_reset catodo", 32'(u_if.catodo), 32'h0D);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset anodo", 32'(u_if.anodo), 32'hF);
    chk("async_reset catodo", 32'(u_if.catodo), 32'hFF);
    chk("async_reset frame_tick", 32'(u_if.frame_tick), 32'd0);
    tick;
    rst_n = 1'b1;
    wait_frame("restart frame_tick", 1);
    check_frame(v, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Downstream neighbour of the 7-segment pattern decoder.
- Takes four active-low 8-bit cathode patterns (catodo1..catodo4) and time-multiplexes them onto one shared cathode bus and four active-low anodes.
- Inserts an all-off blanking interval before each digit slot to suppress ghosting.
- Snapshots all four patterns once per frame, so a frame never mixes old and new values, and emits a frame strobe for upstream logic.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz gives 1 kHz per digit); must be >= 2.
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dig_en  in  4  per-digit enable; bit i enables digit i+1; 0 means the digit stays dark.
- catodo1  in  8  pattern for digit 1 (rightmost); active-low segments, bit0 = dp.
- catodo2  in  8  pattern for digit 2.
- catodo3  in  8  pattern for digit 3.
- catodo4  in  8  pattern for digit 4 (leftmost).
- anodo  out  4  active-low anode drive; bit i drives digit i+1.
- catodo  out  8  shared active-low cathode bus.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: phase=0, idx=0, anodo=4'hF, catodo=8'hFF, frame_tick=0, snapshot registers=8'hFF. Assertion takes effect immediately, mid-slot included.
- phase counter runs 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, idx advances 0->1->2->3->0.
  - Every slot has a fixed length, so refresh rate is independent of dig_en.
- Frame boundary = the edge where idx goes 3->0 (and the first edge after reset release). At that edge:
  - all four catodoN inputs are latched into snap[0..3];
  - dig_en is latched into en_q;
  - frame_tick is 1 for exactly that following cycle.
- States:
  - BLANK while phase < BLANK_CYCLES: anodo=4'hF, catodo=8'hFF.
  - SHOW while phase >= BLANK_CYCLES: if en_q[idx]=1, anodo has only bit idx low and catodo=snap[idx]; otherwise anodo=4'hF and catodo=8'hFF.
- All outputs are registered and computed from next-state values. While the phase register reads p, the outputs reflect state(p) with no extra cycle of lag.
- Each anode is low for exactly REFRESH_DIV-BLANK_CYCLES cycles per frame. Two anodes are never low in the same cycle.
- Input changes mid-frame have no effect until the next frame boundary.
- BLANK_CYCLES=0 is legal: no blanking, and digits switch directly.

Optional Feature:
- Macro: DISPLAY_ZERO_BLANK_EN.
- Defined: leading-zero suppression, evaluated on the snapshot. SEG_ZERO = 8'b00000011.
  - Digit 4 is blanked if snap[3]==SEG_ZERO.
  - Digit 3 is blanked if digit 4 is blanked and snap[2]==SEG_ZERO.
  - Digit 2 is blanked if digit 3 is blanked and snap[1]==SEG_ZERO.
  - Digit 1 is never blanked by this rule.
  - A blanked digit behaves as en_q=0 for that frame.
- Undefined: no suppression; zeros display normally.

Decomposition:
- Package display_pkg holds:
  - constants SEG_OFF=8'hFF, SEG_ZERO=8'b00000011, ANODE_OFF=4'hF;
  - enum scan_state_t {BLANK, SHOW};
  - typedef seg_t = logic [7:0].
- One sub-module, scan_timer, owns the phase counter and idx counter and produces phase, idx and frame boundary.
- display_scan_mux owns the snapshot, the zero-blank logic and the output registers.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset release, dig_en=4'hF, catodo1..4 = 8'h9F, 8'h25, 8'h0D, 8'h99:
  - frame_tick fires once;
  - anodo cycles F,F,E(x6), F,F,D(x6), F,F,B(x6), F,F,7(x6);
  - catodo in SHOW = 9F, 25, 0D, 99;
  - frame_tick then repeats every 32 cycles.
- Change catodo2 to 8'h01 at cycle 12 (mid-frame): digit 2 still shows 8'h25 in that frame and shows 8'h01 from the next frame.
- dig_en=4'b0101: digits 2 and 4 give anodo=F and catodo=FF during their SHOW slots; slot timing is unchanged (frame = 32 cycles).
- Drop rst_n at cycle 20 (during SHOW of digit 3): anodo=F and catodo=FF the same cycle; after release, sequencing restarts at digit 1 with a new frame_tick.
- Build with DISPLAY_ZERO_BLANK_EN, catodo4=03, catodo3=03, catodo2=9F, catodo1=03: digits 4 and 3 dark, digits 2 and 1 lit. Same stimulus without the macro: all four digits lit.
- Over 10 frames, check every cycle that at most one anodo bit is low and catodo==FF whenever anodo==F.
